// File: rtl/sc_hdlc_rx_deframer.sv
// Slow-control HDLC receive deframer: flag hunt, zero de-stuffing, abort detection, octet assembly.
// Optional FCS check (CRC-16/X.25) is built in when SC_RX_FCS_CHECK_EN is defined.
module sc_hdlc_rx_deframer #(
   parameter int unsigned MAX_BYTES = 64,
   parameter int unsigned CNT_W     = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   input  logic       ce,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_sof,
   output logic       out_eof,
   output logic       frame_err,
   output logic       abort,
   output logic       in_frame,
   output logic       fcs_ok
);
   localparam int unsigned ONES_W = 3;
   localparam int unsigned BIT_W  = 3;

   typedef enum logic [1:0] {HUNT, SYNC, FRAME} state_t;

   state_t            state, state_d;
   logic [ONES_W-1:0] ones, ones_d;
   logic [BIT_W-1:0]  bitcnt, bitcnt_d;
   logic [7:0]        shreg, shreg_d;
   logic [7:0]        pend, pend_d;
   logic              pend_vld, pend_vld_d;
   logic              pend_sof, pend_sof_d;
   logic [CNT_W-1:0]  byte_cnt, byte_cnt_d;
   logic [7:0]        out_data_d;
   logic              out_valid_d, out_sof_d, out_eof_d;
   logic              frame_err_d, abort_d, in_frame_d, fcs_ok_d;

   logic              is_stuff_c, is_flag_c, is_abort_c, is_data_c, byte_done_c;
   logic [7:0]        shifted_c;

`ifdef SC_RX_FCS_CHECK_EN
   localparam int unsigned        CRC_W       = 16;
   localparam logic [CRC_W-1:0]   CRC_INIT    = 16'hFFFF;
   localparam logic [CRC_W-1:0]   CRC_POLY    = 16'h8408;
   localparam logic [CRC_W-1:0]   CRC_RESIDUE = 16'hF0B8;

   logic [CRC_W-1:0] crc, crc_d;

   // Reflected CRC-16/X.25, one octet, LSB first
   function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c_in,
                                                 input logic [7:0]       b);
      logic [CRC_W-1:0] c;
      c = c_in ^ {8'h00, b};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction
`endif

   // Next-state, datapath and output decode
   always_comb begin
      state_d     = state;
      ones_d      = ones;
      bitcnt_d    = bitcnt;
      shreg_d     = shreg;
      pend_d      = pend;
      pend_vld_d  = pend_vld;
      pend_sof_d  = pend_sof;
      byte_cnt_d  = byte_cnt;
      out_data_d  = out_data;
      out_valid_d = 1'b0;
      out_sof_d   = 1'b0;
      out_eof_d   = 1'b0;
      frame_err_d = 1'b0;
      abort_d     = 1'b0;
      fcs_ok_d    = 1'b0;
`ifdef SC_RX_FCS_CHECK_EN
      crc_d       = crc;
`endif

      shifted_c   = {din, shreg[7:1]};
      is_stuff_c  = ce && !din && (ones == 3'd5);
      is_flag_c   = ce && !din && (ones == 3'd6);
      is_abort_c  = ce && din && (ones >= 3'd6);
      is_data_c   = ce && !is_stuff_c && !is_flag_c && !is_abort_c;
      byte_done_c = is_data_c && (bitcnt == 3'd7);

      if (ce) begin
         ones_d = din ? ((ones == 3'd7) ? ones : ones + 3'd1) : '0;
      end

      if (is_data_c && (state != HUNT)) begin
         shreg_d  = shifted_c;
         bitcnt_d = bitcnt + 3'd1;
      end

`ifdef SC_RX_FCS_CHECK_EN
      if (is_flag_c) begin
         crc_d = CRC_INIT;
      end else if (byte_done_c && (state != HUNT)) begin
         crc_d = crc_byte(crc, shifted_c);
      end
`endif

      unique case (state)
         HUNT: begin
            if (is_flag_c) begin
               state_d  = SYNC;
               bitcnt_d = '0;
            end
         end
         SYNC: begin
            if (is_abort_c) begin
               state_d  = HUNT;
               bitcnt_d = '0;
            end else if (is_flag_c) begin
               bitcnt_d = '0;
            end else if (byte_done_c) begin
               pend_d     = shifted_c;
               pend_vld_d = 1'b1;
               pend_sof_d = 1'b1;
               byte_cnt_d = CNT_W'(1);
               state_d    = FRAME;
            end
         end
         FRAME: begin
            if (is_abort_c) begin
               abort_d    = 1'b1;
               pend_vld_d = 1'b0;
               state_d    = HUNT;
               bitcnt_d   = '0;
            end else if (is_flag_c) begin
               // Only an octet-aligned flag closes the frame cleanly
               if (bitcnt == 3'd7) begin
                  out_valid_d = pend_vld;
                  out_data_d  = pend;
                  out_sof_d   = pend_vld && pend_sof;
                  out_eof_d   = pend_vld;
`ifdef SC_RX_FCS_CHECK_EN
                  fcs_ok_d    = pend_vld && (crc == CRC_RESIDUE) && (byte_cnt >= CNT_W'(3));
`endif
               end else begin
                  frame_err_d = 1'b1;
               end
               pend_vld_d = 1'b0;
               state_d    = SYNC;
               bitcnt_d   = '0;
            end else if (byte_done_c) begin
               if (byte_cnt == CNT_W'(MAX_BYTES)) begin
                  frame_err_d = 1'b1;
                  pend_vld_d  = 1'b0;
                  state_d     = HUNT;
                  bitcnt_d    = '0;
               end else begin
                  out_valid_d = pend_vld;
                  out_data_d  = pend;
                  out_sof_d   = pend_vld && pend_sof;
                  pend_d      = shifted_c;
                  pend_sof_d  = 1'b0;
                  byte_cnt_d  = byte_cnt + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d  = HUNT;
            bitcnt_d = '0;
         end
      endcase

      in_frame_d = (state_d == FRAME);
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HUNT;
         ones      <= '0;
         bitcnt    <= '0;
         shreg     <= '0;
         pend      <= '0;
         pend_vld  <= 1'b0;
         pend_sof  <= 1'b0;
         byte_cnt  <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
         frame_err <= 1'b0;
         abort     <= 1'b0;
         in_frame  <= 1'b0;
         fcs_ok    <= 1'b0;
`ifdef SC_RX_FCS_CHECK_EN
         crc       <= CRC_INIT;
`endif
      end else begin
         state     <= state_d;
         ones      <= ones_d;
         bitcnt    <= bitcnt_d;
         shreg     <= shreg_d;
         pend      <= pend_d;
         pend_vld  <= pend_vld_d;
         pend_sof  <= pend_sof_d;
         byte_cnt  <= byte_cnt_d;
         out_data  <= out_data_d;
         out_valid <= out_valid_d;
         out_sof   <= out_sof_d;
         out_eof   <= out_eof_d;
         frame_err <= frame_err_d;
         abort     <= abort_d;
         in_frame  <= in_frame_d;
         fcs_ok    <= fcs_ok_d;
`ifdef SC_RX_FCS_CHECK_EN
         crc       <= crc_d;
`endif
      end
   end

endmodule

// File: tb/tb_sc_hdlc_rx_deframer.sv
// Bench for sc_hdlc_rx_deframer: directed HDLC frames, frame-level reference model, per-cycle compare.
module tb_sc_hdlc_rx_deframer;
   localparam int unsigned MAX_BYTES = 64;
   localparam int unsigned CNT_W     = 7;

   logic       clk;
   logic       rst;
   logic       din;
   logic       ce;
   logic [7:0] out_data;
   logic       out_valid, out_sof, out_eof, frame_err, abort, in_frame, fcs_ok;

   sc_hdlc_rx_deframer #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .din(din), .ce(ce),
      .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
      .frame_err(frame_err), .abort(abort), .in_frame(in_frame), .fcs_ok(fcs_ok)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_bad;

   // Reference model: frame as a queue of completed octets
   int         m_run;
   bit         m_hunt;
   int         m_nbits;
   logic [7:0] m_acc;
   logic [7:0] m_q[$];
   logic [9:0] m_log[$];
   int         m_err_cnt, m_abort_cnt;
   bit         m_last_fcs;

   bit         e_valid, e_sof, e_eof, e_err, e_abort, e_inf, e_fcs;
   logic [7:0] e_data;

   logic [9:0] d_log[$];
   int         d_err_cnt, d_abort_cnt;
   bit         d_last_fcs;

   int gap_mode;
   int tx_ones;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [7:0] b);
      logic [15:0] c;
      c = c_in;
      for (int i = 0; i < 8; i++) begin
         if ((c[0] ^ b[i]) == 1'b1) c = (c >> 1) ^ 16'h8408;
         else                       c = c >> 1;
      end
      return c;
   endfunction

   function automatic logic [15:0] crc_of_frame();
      logic [15:0] c;
      c = 16'hFFFF;
      foreach (m_q[i]) c = crc_upd(c, m_q[i]);
      return c;
   endfunction

   task automatic model_reset();
      m_run   = 0;
      m_hunt  = 1'b1;
      m_nbits = 0;
      m_acc   = '0;
      m_q.delete();
   endtask

   task automatic model_emit(input logic [7:0] d, input bit sof, input bit eof);
      e_valid = 1'b1;
      e_data  = d;
      e_sof   = sof;
      e_eof   = eof;
      m_log.push_back({sof, eof, d});
   endtask

   task automatic model_bit(input bit b);
      int prev;
      prev  = m_run;
      m_run = b ? ((m_run < 7) ? m_run + 1 : 7) : 0;
      if (!b && prev == 5) return;
      if (m_hunt) begin
         if (!b && prev == 6) begin
            m_hunt  = 1'b0;
            m_nbits = 0;
         end
         return;
      end
      if (b && prev >= 6) begin
         if (m_q.size() > 0) begin
            e_abort = 1'b1;
            m_abort_cnt++;
         end
         m_hunt = 1'b1;
         m_q.delete();
         return;
      end
      if (!b && prev == 6) begin
         if (m_q.size() > 0) begin
            if (m_nbits == 7) begin
`ifdef SC_RX_FCS_CHECK_EN
               e_fcs = (m_q.size() >= 3) && (crc_of_frame() == 16'hF0B8);
`else
               e_fcs = 1'b0;
`endif
               m_last_fcs = e_fcs;
               model_emit(m_q[m_q.size()-1], m_q.size() == 1, 1'b1);
            end else begin
               e_err = 1'b1;
               m_err_cnt++;
            end
         end
         m_q.delete();
         m_nbits = 0;
         return;
      end
      m_acc[3'(m_nbits)] = b;
      m_nbits++;
      if (m_nbits == 8) begin
         m_nbits = 0;
         if (m_q.size() == MAX_BYTES) begin
            e_err = 1'b1;
            m_err_cnt++;
            m_hunt = 1'b1;
            m_q.delete();
         end else begin
            if (m_q.size() > 0) model_emit(m_q[m_q.size()-1], m_q.size() == 1, 1'b0);
            m_q.push_back(m_acc);
         end
      end
   endtask

   // Per-cycle comparison of DUT against the model
   task automatic compare_cycle();
      chk("out_valid", out_valid, e_valid);
      chk("frame_err", frame_err, e_err);
      chk("abort", abort, e_abort);
      chk("in_frame", in_frame, e_inf);
      if (e_valid) begin
         chk("out_data", out_data, e_data);
         chk("out_sof", out_sof, e_sof);
         chk("out_eof", out_eof, e_eof);
         if (e_eof) chk("fcs_ok", fcs_ok, e_fcs);
      end
      if (out_valid) d_log.push_back({out_sof, out_eof, out_data});
      if (out_valid && out_eof) d_last_fcs = fcs_ok;
      if (frame_err) d_err_cnt++;
      if (abort) d_abort_cnt++;
   endtask

   task automatic step(input bit c, input bit d, input bit r);
      @(negedge clk);
      ce  = c;
      din = d;
      rst = r;
      {e_valid, e_sof, e_eof, e_err, e_abort, e_fcs} = '0;
      if (r) model_reset();
      else if (c) model_bit(d);
      e_inf = !m_hunt && (m_q.size() > 0);
      @(posedge clk);
      #2;
      compare_cycle();
   endtask

   task automatic put_bit(input bit b);
      int g;
      g = (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode;
      for (int i = 0; i < g; i++) step(1'b0, 1'($urandom), 1'b0);
      step(1'b1, b, 1'b0);
   endtask

   task automatic send_flag();
      logic [7:0] f;
      f = 8'h7E;
      for (int i = 0; i < 8; i++) put_bit(f[i]);
      tx_ones = 0;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) begin
         put_bit(v[i]);
         tx_ones = v[i] ? tx_ones + 1 : 0;
         if (tx_ones == 5) begin
            put_bit(1'b0);
            tx_ones = 0;
         end
      end
   endtask

   task automatic send_raw(input logic [7:0] bits, input int n);
      for (int i = 0; i < n; i++) put_bit(bits[3'(i)]);
      tx_ones = 0;
   endtask

   task automatic clear_logs();
      m_log.delete();
      d_log.delete();
      m_err_cnt   = 0;
      m_abort_cnt = 0;
      d_err_cnt   = 0;
      d_abort_cnt = 0;
   endtask

   // Literal expectations on the logged bytes: {sof, eof, data}
   task automatic pin_log(input string name, input int n, input logic [9:0] exp_l [4]);
      chk({name, "_mlen"}, m_log.size(), n);
      chk({name, "_dlen"}, d_log.size(), n);
      for (int i = 0; i < n && i < 4; i++) begin
         if (m_log.size() > i) chk({name, "_mbyte"}, m_log[i], exp_l[i]);
         if (d_log.size() > i) chk({name, "_dbyte"}, d_log[i], exp_l[i]);
      end
   endtask

   task automatic frame_a5_3c(input string name);
      clear_logs();
      send_flag();
      send_byte(8'hA5);
      send_byte(8'h3C);
      send_flag();
      pin_log(name, 2, '{10'h2A5, 10'h13C, 10'h000, 10'h000});
      chk({name, "_err"}, d_err_cnt, 0);
      chk({name, "_abort"}, d_abort_cnt, 0);
   endtask

   initial begin
      logic [15:0] c;
      logic [15:0] fcs;
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      ce  = 1'b0;
      din = 1'b0;
      gap_mode = 0;
      tx_ones  = 0;
      d_last_fcs = 1'b0;
      m_last_fcs = 1'b0;
      e_data = '0;
      model_reset();
      clear_logs();

      repeat (3) step(1'b0, 1'b0, 1'b1);
      chk("reset_outputs", {out_data, out_valid, out_sof, out_eof, frame_err, abort, in_frame, fcs_ok}, 0);
      repeat (2) step(1'b0, 1'b0, 1'b0);

      frame_a5_3c("basic");
      chk("fcs_flag_basic", d_last_fcs, m_last_fcs);

      // All-ones and five-ones octets need stuffed zeros
      clear_logs();
      send_flag();
      send_byte(8'hFF);
      send_byte(8'h1F);
      send_flag();
      pin_log("stuffed", 2, '{10'h2FF, 10'h11F, 10'h000, 10'h000});

      // Abort inside a frame, then a single-byte frame
      clear_logs();
      send_flag();
      send_byte(8'h12);
      send_raw(8'hFF, 8);
      send_flag();
      send_byte(8'h34);
      send_flag();
      pin_log("abort", 1, '{10'h334, 10'h000, 10'h000, 10'h000});
      chk("abort_m_cnt", m_abort_cnt, 1);
      chk("abort_d_cnt", d_abort_cnt, 1);

      // Non-octet frame, then a normal frame
      clear_logs();
      send_flag();
      send_byte(8'h55);
      send_raw(8'h02, 3);
      send_flag();
      send_byte(8'hA5);
      send_byte(8'h3C);
      send_flag();
      pin_log("nonoctet", 3, '{10'h255, 10'h2A5, 10'h13C, 10'h000});
      chk("nonoctet_m_err", m_err_cnt, 1);
      chk("nonoctet_d_err", d_err_cnt, 1);

      // Sparse bit-enable
      gap_mode = -1;
      frame_a5_3c("ce_rand");
      gap_mode = 6;
      frame_a5_3c("ce_1of7");
      gap_mode = 0;

      // Reset in the middle of a frame
      clear_logs();
      send_flag();
      send_byte(8'hA5);
      send_raw(8'h3C, 4);
      step(1'b1, 1'b1, 1'b1);
      chk("midrst_outputs", {out_data, out_valid, out_sof, out_eof, frame_err, abort, in_frame, fcs_ok}, 0);
      tx_ones = 0;
      send_byte(8'h5A);
      send_byte(8'hC3);
      pin_log("midrst_hunt", 0, '{10'h000, 10'h000, 10'h000, 10'h000});
      chk("midrst_err", d_err_cnt, 0);
      frame_a5_3c("after_rst");

      // 65-byte frame overruns at the 65th byte
      clear_logs();
      send_flag();
      for (int i = 1; i <= 65; i++) send_byte(8'(i));
      send_flag();
      chk("long_mlen", m_log.size(), 63);
      chk("long_dlen", d_log.size(), 63);
      if (m_log.size() == 63) begin
         chk("long_m_first", m_log[0], 10'h201);
         chk("long_m_last", m_log[62], 10'h03F);
      end
      if (d_log.size() == 63) begin
         chk("long_d_first", d_log[0], 10'h201);
         chk("long_d_last", d_log[62], 10'h03F);
      end
      chk("long_m_err", m_err_cnt, 1);
      chk("long_d_err", d_err_cnt, 1);
      frame_a5_3c("after_long");

`ifdef SC_RX_FCS_CHECK_EN
      c   = crc_upd(16'hFFFF, 8'h01);
      c   = crc_upd(c, 8'h02);
      fcs = ~c;
      for (int k = 0; k < 2; k++) begin
         clear_logs();
         send_flag();
         send_byte(8'h01);
         send_byte(8'h02);
         send_byte(fcs[7:0] ^ ((k == 1) ? 8'h10 : 8'h00));
         send_byte(fcs[15:8]);
         send_flag();
         chk("fcs_dlen", d_log.size(), 4);
         chk("fcs_m", m_last_fcs, (k == 0) ? 1 : 0);
         chk("fcs_d", d_last_fcs, (k == 0) ? 1 : 0);
      end
`else
      c   = 16'h0;
      fcs = c;
      chk("fcs_off", d_last_fcs, 0);
`endif

      repeat (4) step(1'b0, 1'b0, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
